// File: rtl/systolic_drain.sv
// Drain stage below the PE array: de-skews column partial sums into rows and buffers them in a FIFO.
// Optional `SYSTOLIC_DRAIN_RELU_EN applies ReLU to every element at the push point.
module systolic_drain #(
  parameter int unsigned NUM_BITS   = 16,
  parameter int unsigned NUM_COLS   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_COLS*NUM_BITS-1:0] col_data_i,
  input  logic                         row_start_i,
  output logic [NUM_COLS*NUM_BITS-1:0] row_data_o,
  output logic                         row_valid_o,
  input  logic                         row_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]  count_o,
  output logic                         overflow_o,
  input  logic                         clear_i
);

  localparam int unsigned ROW_W = NUM_COLS * NUM_BITS;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PW    = AW + 1;

  logic [ROW_W-1:0]    aligned;
  logic [ROW_W-1:0]    push_row;
  logic [NUM_COLS-2:0] vld_q;
  logic                push;

  // Row-start tracker; the tail fires when the last column of that row arrives
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= row_start_i;
      for (int unsigned i = 1; i < NUM_COLS - 1; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign push = vld_q[NUM_COLS-2];

  // Column c is delayed NUM_COLS-1-c cycles so every column lines up with the last one
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    if (c == NUM_COLS - 1) begin : g_last
      assign aligned[c*NUM_BITS +: NUM_BITS] = col_data_i[c*NUM_BITS +: NUM_BITS];
    end else begin : g_dly
      localparam int unsigned STAGES = NUM_COLS - 1 - c;
      logic [NUM_BITS-1:0] sk_q [STAGES];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int unsigned s = 0; s < STAGES; s++) begin
            sk_q[s] <= '0;
          end
        end else begin
          sk_q[0] <= col_data_i[c*NUM_BITS +: NUM_BITS];
          for (int unsigned s = 1; s < STAGES; s++) begin
            sk_q[s] <= sk_q[s-1];
          end
        end
      end

      assign aligned[c*NUM_BITS +: NUM_BITS] = sk_q[STAGES-1];
    end
  end

`ifdef SYSTOLIC_DRAIN_RELU_EN
  always_comb begin
    push_row = aligned;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      if (aligned[c*NUM_BITS + NUM_BITS - 1]) begin
        push_row[c*NUM_BITS +: NUM_BITS] = '0;
      end
    end
  end
`else
  assign push_row = aligned;
`endif

  logic [ROW_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_n, rd_n;
  logic [PW-1:0]    count_n;
  logic [ROW_W-1:0] head_n;
  logic             ovf_n, mem_we, empty, full, pop_ok;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok = row_ready_i && !empty;

  // FIFO next state; the head register is preloaded so row_data_o is a flop output
  always_comb begin
    wr_n   = wr_ptr;
    rd_n   = rd_ptr;
    ovf_n  = overflow_o;
    mem_we = 1'b0;
    head_n = row_data_o;
    if (clear_i) begin
      wr_n  = '0;
      rd_n  = '0;
      ovf_n = 1'b0;
    end else begin
      if (pop_ok) begin
        rd_n = rd_ptr + PW'(1);
      end
      if (push) begin
        if (!full || pop_ok) begin
          mem_we = 1'b1;
          wr_n   = wr_ptr + PW'(1);
        end else begin
          ovf_n = 1'b1;
        end
      end
      if (mem_we && (wr_ptr[AW-1:0] == rd_n[AW-1:0])) begin
        head_n = push_row;
      end else begin
        head_n = mem[rd_n[AW-1:0]];
      end
    end
    count_n = wr_n - rd_n;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_o     <= '0;
      row_valid_o <= 1'b0;
      overflow_o  <= 1'b0;
      row_data_o  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      wr_ptr      <= wr_n;
      rd_ptr      <= rd_n;
      count_o     <= count_n;
      row_valid_o <= (count_n != '0);
      overflow_o  <= ovf_n;
      row_data_o  <= head_n;
      if (mem_we) begin
        mem[wr_ptr[AW-1:0]] <= push_row;
      end
    end
  end

endmodule
